// File: rtl/ro_event_packetizer_if.sv
// Event stream handshake between the packetizer and its host-side consumer.
interface ro_event_packetizer_if #(
  parameter int unsigned DW = 20
) ();
  logic [DW-1:0] ev_data;
  logic          ev_valid;
  logic          ev_ready;

  modport master (output ev_data, output ev_valid, input ev_ready);
  modport slave  (input ev_data, input ev_valid, output ev_ready);
endinterface

// File: rtl/ro_event_packetizer.sv
// Readout bus packetizer: tracks the TDM slot, timestamps non-empty samples,
// and buffers event words in a FWFT FIFO behind a valid/ready handshake.
module ro_event_packetizer #(
  parameter int unsigned NUM_CH     = 16,
  parameter int unsigned CH_W       = 4,
  parameter int unsigned TS_W       = 12,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                          clk_master,
  input  logic                          rstb,
  input  logic                          frame_sync,
  input  logic                          capture_en,
  input  logic [1:0]                    read_out_I,
  input  logic [1:0]                    read_out_Q,
  ro_event_packetizer_if.master         ev,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow,
  input  logic                          ovf_clear,
  output logic [7:0]                    drop_cnt
);

  localparam int unsigned DW = TS_W + CH_W + 4;
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned LW = AW + 1;

  typedef struct packed {
    logic [TS_W-1:0] ts;
    logic [CH_W-1:0] slot;
    logic [1:0]      q;
    logic [1:0]      i;
  } ev_word_t;

  logic [CH_W-1:0] slot_q;
  logic [TS_W-1:0] ts_q;
  logic            s1_valid;
  ev_word_t        s1_word;
  ev_word_t        mem [FIFO_DEPTH];
  logic [AW-1:0]   rd_ptr;
  logic [AW-1:0]   wr_ptr;

  logic [CH_W-1:0] samp_slot;
  logic [CH_W-1:0] slot_n;
  logic            last_slot;
  logic            sample_hit;
  ev_word_t        sample_word;
  logic            pop;
  logic            full;
  logic            push_ok;
  logic            drop;
  logic [LW-1:0]   lvl_after_pop;
  logic [LW-1:0]   level_n;
  logic [AW-1:0]   rd_ptr_n;
  ev_word_t        head_n;

  // Slot tracking, sample qualification and FIFO next-state decode.
  always_comb begin
    samp_slot     = frame_sync ? '0 : slot_q;
    last_slot     = (samp_slot == CH_W'(NUM_CH - 1));
    slot_n        = last_slot ? '0 : samp_slot + CH_W'(1);
    sample_hit    = capture_en & ((read_out_I | read_out_Q) != 2'b00);
    sample_word   = '{ts: ts_q, slot: samp_slot, q: read_out_Q, i: read_out_I};
    pop           = ev.ev_valid & ev.ev_ready;
    full          = (fifo_level == LW'(FIFO_DEPTH));
    push_ok       = s1_valid & (~full | pop);
    drop          = s1_valid & full & ~pop;
    lvl_after_pop = fifo_level - LW'(pop);
    level_n       = lvl_after_pop + LW'(push_ok);
    rd_ptr_n      = rd_ptr + AW'(pop);
    head_n        = '0;
    if (level_n != '0) begin
      // An empty-after-pop FIFO takes the incoming word straight to the head.
      head_n = (lvl_after_pop == '0) ? s1_word : mem[rd_ptr_n];
    end
  end

  // Slot/timestamp counters and the stage-1 sample register.
  always_ff @(posedge clk_master) begin
    if (!rstb) begin
      slot_q   <= '0;
      ts_q     <= '0;
      s1_valid <= 1'b0;
      s1_word  <= '0;
    end else begin
      slot_q   <= slot_n;
      if (last_slot) ts_q <= ts_q + TS_W'(1);
      s1_valid <= sample_hit;
      s1_word  <= sample_word;
    end
  end

  // FIFO storage; contents are only read at valid positions, so no reset.
  always_ff @(posedge clk_master) begin
    if (push_ok) mem[wr_ptr] <= s1_word;
  end

  // FIFO pointers, level and registered FWFT head.
  always_ff @(posedge clk_master) begin
    if (!rstb) begin
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      fifo_level  <= '0;
      ev.ev_valid <= 1'b0;
      ev.ev_data  <= '0;
    end else begin
      rd_ptr      <= rd_ptr_n;
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      fifo_level  <= level_n;
      ev.ev_valid <= (level_n != '0);
      ev.ev_data  <= DW'(head_n);
    end
  end

  // Sticky overflow flag and saturating drop counter; a drop beats a clear.
  always_ff @(posedge clk_master) begin
    if (!rstb) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (ovf_clear)             drop_cnt <= 8'd1;
      else if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
    end else if (ovf_clear) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_ro_event_packetizer.sv
// Directed bench for ro_event_packetizer with an ordering scoreboard.
module tb_ro_event_packetizer;

  localparam int unsigned NUM_CH     = 16;
  localparam int unsigned CH_W       = 4;
  localparam int unsigned TS_W       = 8;
  localparam int unsigned FIFO_DEPTH = 16;
  localparam int unsigned DW         = TS_W + CH_W + 4;
  localparam int unsigned LW         = $clog2(FIFO_DEPTH) + 1;

  logic            clk_master = 1'b0;
  logic            rstb;
  logic            frame_sync;
  logic            capture_en;
  logic [1:0]      read_out_I;
  logic [1:0]      read_out_Q;
  logic [LW-1:0]   fifo_level;
  logic            overflow;
  logic            ovf_clear;
  logic [7:0]      drop_cnt;

  ro_event_packetizer_if #(.DW(DW)) ev_if ();

  ro_event_packetizer #(
    .NUM_CH(NUM_CH), .CH_W(CH_W), .TS_W(TS_W), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk_master(clk_master),
    .rstb(rstb),
    .frame_sync(frame_sync),
    .capture_en(capture_en),
    .read_out_I(read_out_I),
    .read_out_Q(read_out_Q),
    .ev(ev_if.master),
    .fifo_level(fifo_level),
    .overflow(overflow),
    .ovf_clear(ovf_clear),
    .drop_cnt(drop_cnt)
  );

  always #5 clk_master = ~clk_master;

  int            n_checks = 0;
  int            n_err    = 0;
  int            m_slot   = 0;
  int            m_ts     = 0;
  logic [DW-1:0] sb [$];
  logic [DW-1:0] w1;
  logic [DW-1:0] w2;

  // Count one comparison and report it if it mismatches.
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Apply one bus cycle, score any pop, advance the slot/ts model, check hold on stall.
  task automatic drive(input logic fs, input logic ce, input logic [1:0] i,
                       input logic [1:0] q, input logic rdy);
    int            ss;
    logic          stall;
    logic [DW-1:0] held;
    frame_sync     = fs;
    capture_en     = ce;
    read_out_I     = i;
    read_out_Q     = q;
    ev_if.ev_ready = rdy;
    stall = ev_if.ev_valid && !rdy && rstb;
    held  = ev_if.ev_data;
    if (ev_if.ev_valid && rdy && rstb) begin
      if (sb.size() == 0) check("sb_underflow", 32'(ev_if.ev_data), 32'hFFFF_FFFF);
      else                check("sb_order", 32'(ev_if.ev_data), 32'(sb.pop_front()));
    end
    @(posedge clk_master);
    if (!rstb) begin
      m_slot = 0;
      m_ts   = 0;
      sb.delete();
    end else begin
      ss = fs ? 0 : m_slot;
      if (ce && ((i | q) != 2'b00)) sb.push_back({TS_W'(m_ts), CH_W'(ss), q, i});
      if (ss == NUM_CH - 1) m_ts = (m_ts + 1) % (1 << TS_W);
      m_slot = (ss == NUM_CH - 1) ? 0 : ss + 1;
    end
    #1;
    if (stall) begin
      check("hold_valid", 32'(ev_if.ev_valid), 32'd1);
      check("hold_data", 32'(ev_if.ev_data), 32'(held));
    end
  endtask

  task automatic idle(input logic rdy);
    drive(1'b0, 1'b0, 2'b00, 2'b00, rdy);
  endtask

  // Abort guard in case the stimulus ever stalls.
  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    ovf_clear = 1'b0;
    rstb      = 1'b0;
    // Reset with bus activity.
    drive(1'b0, 1'b1, 2'b01, 2'b00, 1'b0);
    drive(1'b1, 1'b1, 2'b11, 2'b10, 1'b1);
    check("rst_valid", 32'(ev_if.ev_valid), 32'd0);
    check("rst_level", 32'(fifo_level), 32'd0);
    check("rst_drop", 32'(drop_cnt), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    check("rst_data", 32'(ev_if.ev_data), 32'd0);
    rstb = 1'b1;

    // Single event in slot 3, two-edge latency.
    drive(1'b1, 1'b0, 2'b00, 2'b00, 1'b0);
    idle(1'b0);
    idle(1'b0);
    drive(1'b0, 1'b1, 2'b01, 2'b00, 1'b0);
    check("lat_early", 32'(ev_if.ev_valid), 32'd0);
    idle(1'b0);
    check("single_valid", 32'(ev_if.ev_valid), 32'd1);
    check("single_data", 32'(ev_if.ev_data), 32'h0031);
    check("single_level", 32'(fifo_level), 32'd1);
    idle(1'b1);
    check("pop_valid", 32'(ev_if.ev_valid), 32'd0);
    idle(1'b1);
    check("empty_ready", 32'(fifo_level), 32'd0);

    // Timestamp wrap over 2**TS_W frames.
    for (int f = 0; f < (1 << TS_W); f++)
      for (int s = 0; s < NUM_CH; s++)
        drive((f == 0) && (s == 0), 1'b1,
              ((f == 5) && (s == NUM_CH - 1)) ? 2'b01 : 2'b00, 2'b00, 1'b0);
    drive(1'b0, 1'b1, 2'b00, 2'b01, 1'b0);
    idle(1'b0);
    idle(1'b0);
    check("wrap_level", 32'(fifo_level), 32'd2);
    check("ts_frame5", 32'(ev_if.ev_data), 32'h05F1);
    idle(1'b1);
    check("ts_wrap0", 32'(ev_if.ev_data), 32'h0004);
    idle(1'b1);
    check("wrap_empty", 32'(ev_if.ev_valid), 32'd0);

    // Overflow with 20 back-to-back events.
    for (int k = 0; k < 20; k++)
      drive(1'b0, 1'b1, 2'(k % 3 + 1), 2'(k % 4), 1'b0);
    idle(1'b0);
    idle(1'b0);
    check("ovf_level", 32'(fifo_level), 32'd16);
    check("ovf_drop", 32'(drop_cnt), 32'd4);
    check("ovf_flag", 32'(overflow), 32'd1);
    repeat (4) void'(sb.pop_back());
    ovf_clear = 1'b1;
    idle(1'b0);
    ovf_clear = 1'b0;
    check("clr_flag", 32'(overflow), 32'd0);
    check("clr_drop", 32'(drop_cnt), 32'd0);

    // Drop coinciding with clear: the drop wins.
    drive(1'b0, 1'b1, 2'b01, 2'b00, 1'b0);
    ovf_clear = 1'b1;
    idle(1'b0);
    ovf_clear = 1'b0;
    check("win_flag", 32'(overflow), 32'd1);
    check("win_drop", 32'(drop_cnt), 32'd1);
    void'(sb.pop_back());
    ovf_clear = 1'b1;
    idle(1'b0);
    ovf_clear = 1'b0;
    check("clr2_drop", 32'(drop_cnt), 32'd0);

    // Push and pop together while full.
    drive(1'b0, 1'b1, 2'b10, 2'b01, 1'b0);
    idle(1'b1);
    check("fullpp_level", 32'(fifo_level), 32'd16);
    check("fullpp_drop", 32'(drop_cnt), 32'd0);
    check("fullpp_ovf", 32'(overflow), 32'd0);
    repeat (16) idle(1'b1);
    check("drain_level", 32'(fifo_level), 32'd0);
    check("drain_sb", 32'(sb.size()), 32'd0);

    // Mid-frame realign at slot 7.
    drive(1'b1, 1'b0, 2'b00, 2'b00, 1'b0);
    repeat (5) idle(1'b0);
    drive(1'b0, 1'b1, 2'b01, 2'b00, 1'b0);
    drive(1'b1, 1'b1, 2'b00, 2'b10, 1'b0);
    idle(1'b0);
    check("realign_level", 32'(fifo_level), 32'd2);
    w1 = ev_if.ev_data;
    check("pre_slot", 32'(w1[CH_W+3:4]), 32'd6);
    idle(1'b1);
    w2 = ev_if.ev_data;
    check("realign_slot", 32'(w2[CH_W+3:4]), 32'd0);
    check("realign_ts", 32'(w2[DW-1:CH_W+4]), 32'(w1[DW-1:CH_W+4]));
    idle(1'b1);

    // Random traffic with random backpressure.
    for (int k = 0; k < 80; k++)
      drive($urandom_range(0, 15) == 0, $urandom_range(0, 2) == 0,
            2'($urandom), 2'($urandom), 1'($urandom_range(0, 1)));
    for (int k = 0; k < 40 && (ev_if.ev_valid || sb.size() != 0); k++) idle(1'b1);
    check("rand_sb", 32'(sb.size()), 32'd0);
    check("rand_level", 32'(fifo_level), 32'd0);
    check("rand_drop", 32'(drop_cnt), 32'd0);

    // Reset mid-operation discards buffered and staged events.
    repeat (3) drive(1'b0, 1'b1, 2'b01, 2'b00, 1'b0);
    rstb = 1'b0;
    idle(1'b0);
    rstb = 1'b1;
    check("mrst_valid", 32'(ev_if.ev_valid), 32'd0);
    check("mrst_level", 32'(fifo_level), 32'd0);
    check("mrst_data", 32'(ev_if.ev_data), 32'd0);
    idle(1'b0);
    check("mrst_stage", 32'(ev_if.ev_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
